cpu_bus_decoder: RTL and testbench
==================================

Name: cpu_bus_decoder

Overview:
- Sits between cpu_wrapper (host) and the per-device slots of the CPU bus (RAM, bootloader, GPIO, I2C, USB, UART, DMA, CFG, SDRAM).
- Decodes each single-cycle host request by address[31:28] and forwards it to exactly one device slot.
- Returns the selected device's ack and read data to the host.
- Terminates requests to unmapped slots and requests that time out, so the CPU can never hang on a dead device, and records the fault in a sticky error register.

Parameters:
- DEVICES, 16, number of device slots, 1..16; slot index = address[31:28].
- PRESENT, 16'hFFFF, bit i set = slot i populated; unpopulated slots are unmapped.
- TIMEOUT, 1024, cycles to wait for a device ack before forced termination; minimum 2.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- host_request  input  1  one-cycle request pulse from CPU.
- host_wmask  input  4  byte write enables; 0 = read.
- host_address  input  32  byte address.
- host_wdata  input  32  write data.
- host_ack  output  1  one-cycle completion pulse.
- host_rdata  output  32  read data, valid while host_ack=1.
- dev_request  output  DEVICES  one-hot request pulse to slot.
- dev_wmask  output  4  broadcast, registered.
- dev_address  output  32  broadcast, registered.
- dev_wdata  output  32  broadcast, registered.
- dev_ack  input  DEVICES  per-slot ack pulses.
- dev_rdata  input  32*DEVICES  per-slot read data; slot i at bits [32*i+31:32*i].
- error  output  1  sticky fault flag.
- error_id  output  4  slot of first fault since clear.
- error_timeout  output  1  1 = timeout, 0 = unmapped.
- error_clear  input  1  clears error, error_id and error_timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction aborts the transaction with no host_ack.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE + host_request:
  - Latch wmask, address and wdata onto the dev_* buses; capture slot id = address[31:28].
  - Mapped slot (id < DEVICES and PRESENT[id]): dev_request[id]=1 for exactly one cycle (cycle t+1 after a request at cycle t), then go to WAIT.
  - Unmapped slot: no dev_request. Go to DONE, host_ack=1 at t+1 with rdata=0, set error fault type unmapped.
- WAIT:
  - Counter increments each cycle from 0.
  - dev_ack[id] at cycle u: host_ack=1 and host_rdata=dev_rdata[id] at u+1, then return to IDLE.
  - Counter reaches TIMEOUT-1 with no ack: host_ack=1 with TIMEOUT_RDATA next cycle, set fault type timeout, return to IDLE.
  - An ack arriving in the same cycle as expiry wins; no fault is recorded.
- DONE: single cycle carrying host_ack, then IDLE.
- dev_ack bits from non-selected slots and any dev_ack in IDLE are ignored.
- dev_* broadcast buses hold their last value between transactions.
- host_request while not IDLE is a protocol violation: ignored, no state change.
- Minimum host-visible latency is 2 cycles (request at t, device acks at t+1, host_ack at t+2). Back-to-back requests are accepted one cycle after host_ack.
- host_rdata returns to 0 in the cycle after host_ack.
- Error register:
  - On a fault, if error=0: set error=1, latch error_id and error_timeout.
  - If error=1: later faults do not overwrite the captured fields.
  - error_clear has priority over a simultaneous new fault: after clear, the fault in the same cycle is lost.
- Timeout counter width is $clog2(TIMEOUT); it saturates and never wraps.

Decomposition:
- Shared package sc64 carries:
  - slot id typedef (4-bit).
  - FSM state enum.
  - default TIMEOUT and TIMEOUT_RDATA constants.
  - slot id constants, which already exist as ID_CPU_*.
- Sub-module cpu_bus_timeout: counter with start/clear/expired, reused later by the DMA path.
- The response mux stays inline.

Test Plan:
- Read to slot 2: address 0x2000_0010, wmask 0, device acks 3 cycles later with 0x1234_5678 -> host_ack 1 cycle after dev_ack, rdata 0x1234_5678, dev_request=16'h0004 for one cycle, error=0.
- Write to slot 5: wmask 4'hF, wdata 0xA5A5_A5A5, device acks at t+1 -> dev_wdata/dev_wmask match, host_ack at t+2.
- Unmapped: PRESENT=16'h00FF, address 0xC000_0000 -> no dev_request, host_ack at t+1 with rdata 0, error=1, error_id=12, error_timeout=0.
- Timeout: TIMEOUT=8, slot 3 never acks -> host_ack exactly 8 cycles after dev_request, rdata 0xDEAD_BEEF, error_timeout=1. A second timeout on slot 4 leaves error_id=3. error_clear clears all three.
- Race and noise: dev_ack[3] in the expiry cycle -> normal data returned, no error. dev_ack[7] while slot 3 is selected is ignored. host_request during WAIT is ignored.
- Reset asserted in WAIT -> no host_ack, all outputs 0. The next request after reset completes normally.

Source files
------------

// File: rtl/sc64_pkg.sv
// Shared types and constants for the sc64 CPU bus.
package sc64;

    typedef logic [3:0] slot_id_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } bus_state_t;

    localparam int unsigned DEF_TIMEOUT       = 1024;
    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    localparam slot_id_t ID_CPU_RAM        = 4'd0;
    localparam slot_id_t ID_CPU_BOOTLOADER = 4'd1;
    localparam slot_id_t ID_CPU_GPIO       = 4'd2;
    localparam slot_id_t ID_CPU_I2C        = 4'd3;
    localparam slot_id_t ID_CPU_USB        = 4'd4;
    localparam slot_id_t ID_CPU_UART       = 4'd5;
    localparam slot_id_t ID_CPU_DMA        = 4'd6;
    localparam slot_id_t ID_CPU_CFG        = 4'd7;
    localparam slot_id_t ID_CPU_SDRAM      = 4'd8;

endpackage

// File: rtl/cpu_bus_timeout.sv
// Saturating wait counter; expired holds once TIMEOUT-1 cycles have elapsed.
module cpu_bus_timeout
    import sc64::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;
    logic         running;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
        end else if (running && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = running && (count == LAST);

endmodule

// File: rtl/cpu_bus_decoder.sv
// Host-to-device CPU bus decoder: routes one request per slot, terminates
// dead or unmapped slots, and keeps a sticky record of the first fault.
module cpu_bus_decoder
    import sc64::*;
#(
    parameter int          DEVICES       = 16,
    parameter logic [15:0] PRESENT       = 16'hFFFF,
    parameter int          TIMEOUT       = DEF_TIMEOUT,
    parameter logic [31:0] TIMEOUT_RDATA = DEF_TIMEOUT_RDATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_request,
    input  logic [3:0]            host_wmask,
    input  logic [31:0]           host_address,
    input  logic [31:0]           host_wdata,
    output logic                  host_ack,
    output logic [31:0]           host_rdata,
    output logic [DEVICES-1:0]    dev_request,
    output logic [3:0]            dev_wmask,
    output logic [31:0]           dev_address,
    output logic [31:0]           dev_wdata,
    input  logic [DEVICES-1:0]    dev_ack,
    input  logic [32*DEVICES-1:0] dev_rdata,
    output logic                  error,
    output logic [3:0]            error_id,
    output logic                  error_timeout,
    input  logic                  error_clear
);

    bus_state_t         state;
    slot_id_t           sel;
    logic [DEVICES-1:0] hit;
    logic               mapped;
    logic               sel_ack;
    logic [31:0]        sel_rdata;
    logic               expired;
    logic               tmr_start;
    logic               tmr_clear;
    logic               fault;
    logic               fault_to;
    slot_id_t           fault_id;

    always_comb begin
        hit       = '0;
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < DEVICES; i++) begin
            hit[i] = host_address[31:28] == slot_id_t'(i);
            if (sel == slot_id_t'(i)) begin
                sel_ack   = dev_ack[i];
                sel_rdata = dev_rdata[32*i +: 32];
            end
        end
    end

    assign mapped    = |(hit & PRESENT[DEVICES-1:0]);
    assign tmr_start = (state == IDLE) && host_request && mapped;
    assign tmr_clear = (state == WAIT) && (sel_ack || expired);

    // A late ack in the expiry cycle still wins, so it suppresses the fault.
    assign fault_to = (state == WAIT) && !sel_ack && expired;
    assign fault    = fault_to
                    || ((state == IDLE) && host_request && !mapped);
    assign fault_id = (state == WAIT) ? sel : host_address[31:28];

    cpu_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .start  (tmr_start),
        .clear  (tmr_clear),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            dev_request <= '0;
            dev_wmask   <= '0;
            dev_address <= '0;
            dev_wdata   <= '0;
        end else begin
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            dev_request <= '0;
            unique case (state)
                IDLE: begin
                    if (host_request) begin
                        dev_wmask   <= host_wmask;
                        dev_address <= host_address;
                        dev_wdata   <= host_wdata;
                        sel         <= host_address[31:28];
                        if (mapped) begin
                            dev_request <= hit;
                            state       <= WAIT;
                        end else begin
                            host_ack <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (sel_ack) begin
                        host_ack   <= 1'b1;
                        host_rdata <= sel_rdata;
                        state      <= IDLE;
                    end else if (expired) begin
                        host_ack   <= 1'b1;
                        host_rdata <= TIMEOUT_RDATA;
                        state      <= IDLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error         <= 1'b0;
            error_id      <= '0;
            error_timeout <= 1'b0;
        end else if (error_clear) begin
            error         <= 1'b0;
            error_id      <= '0;
            error_timeout <= 1'b0;
        end else if (fault && !error) begin
            error         <= 1'b1;
            error_id      <= fault_id;
            error_timeout <= fault_to;
        end
    end

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Randomised bench for cpu_bus_decoder against a transaction-level
// schedule of expected per-cycle outputs.
module tb_cpu_bus_decoder;

    localparam int          DEV   = 16;
    localparam logic [15:0] PRES  = 16'h00FF;
    localparam int          TO    = 8;
    localparam logic [31:0] TO_RD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         host_request = 1'b0;
    logic [3:0]   host_wmask = '0;
    logic [31:0]  host_address = '0;
    logic [31:0]  host_wdata = '0;
    logic         host_ack;
    logic [31:0]  host_rdata;
    logic [15:0]  dev_request;
    logic [3:0]   dev_wmask;
    logic [31:0]  dev_address;
    logic [31:0]  dev_wdata;
    logic [15:0]  dev_ack = '0;
    logic [511:0] dev_rdata = '0;
    logic         error;
    logic [3:0]   error_id;
    logic         error_timeout;
    logic         error_clear = 1'b0;

    cpu_bus_decoder #(
        .DEVICES      (DEV),
        .PRESENT      (PRES),
        .TIMEOUT      (TO),
        .TIMEOUT_RDATA(TO_RD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_request (host_request),
        .host_wmask   (host_wmask),
        .host_address (host_address),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .dev_request  (dev_request),
        .dev_wmask    (dev_wmask),
        .dev_address  (dev_address),
        .dev_wdata    (dev_wdata),
        .dev_ack      (dev_ack),
        .dev_rdata    (dev_rdata),
        .error        (error),
        .error_id     (error_id),
        .error_timeout(error_timeout),
        .error_clear  (error_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events keyed by the cycle in which they become visible.
    logic [31:0] e_ack [int];
    logic [15:0] e_req [int];
    logic [67:0] e_bus [int];
    logic [4:0]  e_flt [int];
    bit          e_clr [int];

    logic        m_err = 1'b0;
    logic        m_to = 1'b0;
    logic [3:0]  m_id = '0;
    logic [67:0] m_bus = '0;
    logic [15:0] pres_v = PRES;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acks = 0;
    int          last_ack_cyc = -1;
    logic [31:0] last_ack_rd = '0;

    function automatic void chk(string name, logic [67:0] act, logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        e_ack.delete();
        e_req.delete();
        e_bus.delete();
        e_flt.delete();
        e_clr.delete();
        m_err = 1'b0;
        m_to  = 1'b0;
        m_id  = '0;
        m_bus = '0;
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] exp_rd;
        logic        exp_ack;
        logic [15:0] exp_req;
        if (e_clr.exists(cyc)) begin
            m_err = 1'b0;
            m_to  = 1'b0;
            m_id  = '0;
        end else if (e_flt.exists(cyc) && !m_err) begin
            m_err = 1'b1;
            {m_to, m_id} = e_flt[cyc];
        end
        if (e_bus.exists(cyc)) m_bus = e_bus[cyc];
        exp_ack = 1'b0;
        exp_rd  = '0;
        exp_req = '0;
        if (e_ack.exists(cyc)) begin
            exp_ack = 1'b1;
            exp_rd  = e_ack[cyc];
        end
        if (e_req.exists(cyc)) exp_req = e_req[cyc];
        chk("host_ack", host_ack, exp_ack);
        chk("host_rdata", host_rdata, exp_rd);
        chk("dev_request", dev_request, exp_req);
        chk("dev_bus", {dev_wmask, dev_address, dev_wdata}, m_bus);
        chk("error_reg", {error, error_timeout, error_id}, {m_err, m_to, m_id});
        if (host_ack) begin
            last_ack_cyc = cyc;
            last_ack_rd  = host_rdata;
            n_acks++;
        end
    end

    task automatic idle(input int n, input bit noise);
        repeat (n) begin
            dev_ack = noise ? 16'($urandom) : 16'h0;
            @(posedge clk);
            #1;
        end
        dev_ack = '0;
    endtask

    // d = device ack delay after dev_request; d < 0 means never.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wm,
                          input logic [31:0] wd, input int d,
                          input logic [31:0] rd, input bit noise,
                          input int clr_off, output int lat,
                          output logic [31:0] ord);
        int          t;
        int          ack_c;
        logic [3:0]  s;
        bit          mp;
        logic [15:0] oh;
        t  = cyc;
        s  = addr[31:28];
        mp = pres_v[s];
        oh = 16'(1) << s;
        e_bus[t+1] = {wm, addr, wd};
        if (!mp) begin
            ack_c        = t + 1;
            e_ack[ack_c] = '0;
            e_flt[ack_c] = {1'b0, s};
        end else begin
            e_req[t+1] = oh;
            if (d >= 0 && d < TO) begin
                ack_c        = t + 2 + d;
                e_ack[ack_c] = rd;
            end else begin
                ack_c        = t + 1 + TO;
                e_ack[ack_c] = TO_RD;
                e_flt[ack_c] = {1'b1, s};
            end
        end
        if (clr_off >= 0) e_clr[t+clr_off+1] = 1'b1;
        for (int c = t; c <= ack_c; c++) begin
            host_request = (c == t)
                || (noise && mp && c > t && c < ack_c && $urandom_range(3) == 0);
            host_wmask   = (c == t) ? wm : 4'($urandom);
            host_address = (c == t) ? addr : $urandom;
            host_wdata   = (c == t) ? wd : $urandom;
            error_clear  = (c == t + clr_off);
            dev_ack      = noise ? (16'($urandom) & ~oh) : 16'h0;
            for (int i = 0; i < DEV; i++) dev_rdata[32*i +: 32] = $urandom;
            if (mp && d >= 0 && c == t + 1 + d) begin
                dev_ack |= oh;
                dev_rdata[32*s +: 32] = rd;
            end
            @(posedge clk);
            #1;
        end
        host_request = 1'b0;
        error_clear  = 1'b0;
        dev_ack      = '0;
        lat = last_ack_cyc - t;
        ord = last_ack_rd;
    endtask

    task automatic clear_err();
        e_clr[cyc+1] = 1'b1;
        error_clear  = 1'b1;
        @(posedge clk);
        #1;
        error_clear = 1'b0;
    endtask

    initial begin : drive
        int          lat;
        int          t;
        int          k;
        int          d;
        int          co;
        logic [31:0] rdv;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b1);

        do_txn(32'h2000_0010, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0, -1, lat, rdv);
        chk("rd2_latency", lat, 5);
        chk("rd2_rdata", rdv, 32'h1234_5678);
        chk("rd2_error", error, 1'b0);

        do_txn(32'h5000_0020, 4'hF, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, -1, lat, rdv);
        chk("wr5_latency", lat, 2);
        chk("wr5_wdata", dev_wdata, 32'hA5A5_A5A5);
        chk("wr5_wmask", dev_wmask, 4'hF);

        do_txn(32'hC000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, -1, lat, rdv);
        chk("unmap_latency", lat, 1);
        chk("unmap_rdata", rdv, 32'h0);
        chk("unmap_err", {error, error_timeout, error_id}, {1'b1, 1'b0, 4'd12});
        clear_err();

        do_txn(32'h3000_0000, 4'h0, 32'h0, -1, 32'h0, 1'b0, -1, lat, rdv);
        chk("to3_latency", lat, 9);
        chk("to3_rdata", rdv, 32'hDEAD_BEEF);
        chk("to3_err", {error, error_timeout, error_id}, {1'b1, 1'b1, 4'd3});
        do_txn(32'h4000_0000, 4'h0, 32'h0, -1, 32'h0, 1'b0, -1, lat, rdv);
        chk("to4_sticky_id", error_id, 4'd3);
        clear_err();
        chk("clear_all", {error, error_timeout, error_id}, 6'h0);

        do_txn(32'h3000_0004, 4'h0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b1, -1, lat, rdv);
        chk("race_latency", lat, 9);
        chk("race_rdata", rdv, 32'h0BAD_F00D);
        chk("race_no_error", error, 1'b0);

        do_txn(32'hE000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, 0, lat, rdv);
        chk("clear_beats_fault", error, 1'b0);

        do_txn(32'hF000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0, -1, lat, rdv);
        t = cyc;
        host_request = 1'b1;
        host_address = 32'h3000_0040;
        host_wmask   = 4'h0;
        host_wdata   = 32'h0;
        e_bus[t+1]   = {4'h0, 32'h3000_0040, 32'h0};
        e_req[t+1]   = 16'h0008;
        @(posedge clk);
        #1;
        host_request = 1'b0;
        idle(3, 1'b0);
        k = n_acks;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_outputs", {host_ack, dev_request, dev_address, error}, '0);
        idle(2, 1'b1);
        reset = 1'b0;
        idle(2, 1'b0);
        chk("rst_no_ack", n_acks, k);
        do_txn(32'h3000_0008, 4'h0, 32'h0, 1, 32'h7777_1111, 1'b0, -1, lat, rdv);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rdv, 32'h7777_1111);

        for (int n = 0; n < 150; n++) begin
            d = int'($urandom_range(TO + 2));
            if ($urandom_range(5) == 0) d = -1;
            co = ($urandom_range(9) == 0) ? int'($urandom_range(1)) : -1;
            do_txn($urandom, 4'($urandom), $urandom, d, $urandom, 1'b1, co, lat, rdv);
            idle(int'($urandom_range(2)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
